// File: rtl/image_loader_if.sv
// Loader-side view of the UART byte stream (in) and the RAM-controller write bus (out).
// master = image_loader, slave = byte source plus RAM controller.
interface image_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic        bus_ce_o;
    logic        bus_we_o;
    logic        bus_ack_i;

    modport master (
        input  byte_valid, byte_data, bus_ack_i,
        output byte_ready, bus_addr_o, bus_data_o, bus_ce_o, bus_we_o
    );

    modport slave (
        output byte_valid, byte_data, bus_ack_i,
        input  byte_ready, bus_addr_o, bus_data_o, bus_ce_o, bus_we_o
    );
endinterface

// File: rtl/image_loader.sv
// image_loader: packs UART bytes little-endian into 32-bit words, writes them to BASE_ADDR+n; optional checksum via LOADER_CSUM_EN.
// Latency: >= 5 cycles per word (4 byte accepts + 1-cycle ack); every output is registered.
// Backpressure: byte_ready only in COLLECT; a write holds addr/data/ce until bus_ack_i.
module image_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LEN_W     = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len_i,
    image_loader_if.master   bus,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] words_o,
    output logic [31:0]      csum_o
);
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [1:0]       idx;
    logic [23:0]      lanes_q;
    logic [LEN_W-1:0] words_nxt;

    assign words_nxt = words_o + LEN_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            len_q          <= '0;
            idx            <= '0;
            lanes_q        <= '0;
            bus.byte_ready <= 1'b0;
            bus.bus_addr_o <= '0;
            bus.bus_data_o <= '0;
            bus.bus_ce_o   <= 1'b0;
            bus.bus_we_o   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            words_o        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        done    <= 1'b0;
                        words_o <= '0;
                        idx     <= '0;
                        if (len_i != '0) begin
                            len_q          <= len_i;
                            busy           <= 1'b1;
                            bus.byte_ready <= 1'b1;
                            state          <= COLLECT;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                // byte_ready is held high for the whole of COLLECT
                COLLECT: begin
                    if (bus.byte_valid) begin
                        idx <= idx + 2'd1;
                        case (idx)
                            2'd0: lanes_q[7:0]   <= bus.byte_data;
                            2'd1: lanes_q[15:8]  <= bus.byte_data;
                            2'd2: lanes_q[23:16] <= bus.byte_data;
                            default: begin
                                bus.bus_data_o <= {bus.byte_data, lanes_q};
                                bus.bus_addr_o <= BASE_ADDR + 32'(words_o);
                                bus.bus_ce_o   <= 1'b1;
                                bus.bus_we_o   <= 1'b1;
                                bus.byte_ready <= 1'b0;
                                state          <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (bus.bus_ack_i) begin
                        bus.bus_ce_o <= 1'b0;
                        bus.bus_we_o <= 1'b0;
                        words_o      <= words_nxt;
                        if (words_nxt == len_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            bus.byte_ready <= 1'b1;
                            state          <= COLLECT;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOADER_CSUM_EN
    logic start_acc;
    logic wr_ack;

    assign start_acc = (state == IDLE) && start;
    assign wr_ack    = (state == WRITE) && bus.bus_ack_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_o <= '0;
        end else if (start_acc) begin
            csum_o <= '0;
        end else if (wr_ack) begin
            csum_o <= csum_o + bus.bus_data_o;
        end
    end
`else
    assign csum_o = '0;
`endif

endmodule

// File: tb/tb_image_loader.sv
// Randomized scoreboard bench for image_loader: a driver pushes expected writes, a bus monitor/responder pops and compares.
module tb_image_loader;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          LW   = 20;

    logic          clk;
    logic          rst;
    logic          start;
    logic [LW-1:0] len_i;
    logic          busy;
    logic          done;
    logic [LW-1:0] words_o;
    logic [31:0]   csum_o;

    image_loader_if iface();

    image_loader #(.BASE_ADDR(BASE), .LEN_W(LW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len_i   (len_i),
        .bus     (iface),
        .busy    (busy),
        .done    (done),
        .words_o (words_o),
        .csum_o  (csum_o)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] wbuf[16];
    int          cur_len;
    int          words_exp;
    logic [31:0] csum_exp;
    int          ack_dly;
    bit          stray_en;
    bit          abort;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_byte_ready"}, 32'(iface.byte_ready), 0);
        chk({tag, "_ce"},         32'(iface.bus_ce_o), 0);
        chk({tag, "_we"},         32'(iface.bus_we_o), 0);
        chk({tag, "_addr"},       iface.bus_addr_o, 0);
        chk({tag, "_data"},       iface.bus_data_o, 0);
        chk({tag, "_busy"},       32'(busy), 0);
        chk({tag, "_done"},       32'(done), 0);
        chk({tag, "_words"},      32'(words_o), 0);
        chk({tag, "_csum"},       csum_o, 0);
    endtask

    // Bus responder and scoreboard checker
    initial begin
        bit          in_wr = 0;
        bit          ack_prev = 0;
        int          wcnt = 0;
        logic [31:0] cur_addr = '0;
        logic [31:0] cur_data = '0;
        iface.bus_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_wr = 0;
                ack_prev = 0;
                iface.bus_ack_i = 1'b0;
                continue;
            end
            if (ack_prev) begin
                ack_prev = 0;
                in_wr = 0;
                words_exp++;
`ifdef LOADER_CSUM_EN
                csum_exp = csum_exp + cur_data;
`endif
                chk("ce_drop_after_ack", 32'(iface.bus_ce_o), 0);
                chk("words_after_ack", 32'(words_o), 32'(words_exp));
                chk("csum_after_ack", csum_o, csum_exp);
                if (words_exp == cur_len) begin
                    chk("done_after_last_ack", 32'(done), 1);
                    chk("busy_after_last_ack", 32'(busy), 0);
                end else begin
                    chk("ready_after_ack", 32'(iface.byte_ready), 1);
                    chk("busy_after_ack", 32'(busy), 1);
                end
            end
            if (iface.bus_ce_o) begin
                if (!in_wr) begin
                    in_wr = 1;
                    wcnt = 0;
                    cur_addr = iface.bus_addr_o;
                    cur_data = iface.bus_data_o;
                    if (exp_addr.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h with no write expected", cur_addr, cur_data);
                    end else begin
                        chk("write_addr", cur_addr, exp_addr.pop_front());
                        chk("write_data", cur_data, exp_data.pop_front());
                    end
                    chk("write_we", 32'(iface.bus_we_o), 1);
                end else begin
                    chk("addr_stable", iface.bus_addr_o, cur_addr);
                    chk("data_stable", iface.bus_data_o, cur_data);
                    chk("we_stable", 32'(iface.bus_we_o), 1);
                end
                chk("ready_low_in_write", 32'(iface.byte_ready), 0);
                if (wcnt >= ack_dly) begin
                    iface.bus_ack_i = 1'b1;
                    ack_prev = 1;
                end else begin
                    iface.bus_ack_i = 1'b0;
                end
                wcnt++;
            end else begin
                iface.bus_ack_i = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        iface.byte_valid = 1'b1;
        iface.byte_data  = b;
        while (!iface.byte_ready && !abort && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!abort) begin
            if (t >= 500) begin
                n_chk++;
                n_fail++;
                $display("FAIL byte_accept_timeout: byte_ready stayed 0, required 1 within 500 cycles");
            end else begin
                @(posedge clk);
            end
        end
        #1;
        iface.byte_valid = 1'b0;
        iface.byte_data  = 8'($urandom);
    endtask

    task automatic do_load(input int len, input int gap_max, input int dly);
        int t;
        ack_dly   = dly;
        cur_len   = len;
        words_exp = 0;
        csum_exp  = '0;
        for (int w = 0; w < len; w++) begin
            exp_addr.push_back(BASE + 32'(w));
            exp_data.push_back(wbuf[w]);
        end
        @(negedge clk);
        start = 1'b1;
        len_i = LW'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
        len_i = LW'($urandom);
        @(negedge clk);
        chk("start_busy", 32'(busy), 32'(len != 0));
        chk("start_done_cleared", 32'(done), 0);
        chk("start_ready", 32'(iface.byte_ready), 32'(len != 0));
        chk("start_words_cleared", 32'(words_o), 0);
        if (len == 0) begin
            @(negedge clk);
            chk("zero_len_done", 32'(done), 1);
            chk("zero_len_busy", 32'(busy), 0);
            chk("zero_len_words", 32'(words_o), 0);
            return;
        end
        for (int w = 0; w < len; w++) begin
            for (int b = 0; b < 4; b++) begin
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
                if (abort) return;
                send_byte(wbuf[w][8*b +: 8]);
            end
        end
        t = 0;
        while (!done && !abort && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (abort) return;
        if (t >= 2000) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: done stayed 0, required 1 within 2000 cycles");
        end
        chk("final_words", 32'(words_o), 32'(len));
        chk("final_csum", csum_o, csum_exp);
        chk("final_busy", 32'(busy), 0);
        chk("final_writes_pending", 32'(exp_addr.size()), 0);
        repeat (3) @(negedge clk);
        chk("done_held_in_idle", 32'(done), 1);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        len_i = '0;
        iface.byte_valid = 1'b0;
        iface.byte_data = 8'h00;
        abort = 0;
        stray_en = 0;
        ack_dly = 0;
        cur_len = 0;
        words_exp = 0;
        csum_exp = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        wbuf[0] = 32'h1234_5678;
        do_load(1, 0, 0);

        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        do_load(3, 3, 4);

        do_load(0, 0, 0);

        wbuf[0] = 32'hFFFF_FFFF;
        wbuf[1] = 32'h0000_0002;
        do_load(2, 1, 1);
`ifdef LOADER_CSUM_EN
        chk("csum_wrap", csum_o, 32'h0000_0001);
`else
        chk("csum_disabled", csum_o, 32'h0000_0000);
`endif

        // start pulse with a larger length in the middle of a two-word load
        for (int i = 0; i < 2; i++) wbuf[i] = $urandom;
        fork
            do_load(2, 2, 2);
            begin
                repeat (8) @(negedge clk);
                start = 1'b1;
                len_i = LW'(9);
                @(negedge clk);
                start = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        chk("busy_start_ignored_words", 32'(words_o), 2);
        chk("busy_start_ignored_busy", 32'(busy), 0);

        stray_en = 1;
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) wbuf[i] = $urandom;
            do_load(n, 3, $urandom_range(0, 4));
        end
        stray_en = 0;

        // asynchronous reset while the third of four writes is on the bus
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        fork
            do_load(4, 1, 3);
            begin
                int t = 0;
                while (!(iface.bus_ce_o && words_o == LW'(2)) && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 2000) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL reset_trigger_timeout: third write never reached the bus");
                end
                #1;
                rst = 1'b0;
                abort = 1;
                #1;
                chk_all_zero("async_reset");
            end
        join
        exp_addr.delete();
        exp_data.delete();
        repeat (2) @(negedge clk);
        chk_all_zero("reset_held");
        abort = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) wbuf[i] = $urandom;
        do_load(2, 2, 1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/image_loader.md
# image_loader

Bus master that fills program memory before the CPU runs. It accepts a byte stream from a UART receiver, packs each four bytes little-endian into a 32-bit word, and writes the words to consecutive word addresses through the memory bus handshake (addr/data/ce/we/ack) of the RAM controller. It sits directly upstream of that controller. It replaces the compiled-in image table for boards that load programs at run time.

## Interface
- `BASE_ADDR`, default 32'h00000000: word address of the first written word.
- `LEN_W`, default 20: width of the length and count fields; matches the 20-bit SRAM word address.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a load; sampled only in IDLE.
- `len_i` in LEN_W: number of words to load; latched when `start` is accepted.
- `byte_valid` in 1: upstream byte present.
- `byte_data` in 8: byte value.
- `byte_ready` out 1: loader accepts the byte this cycle.
- `bus_addr_o` out 32: word address to the RAM controller.
- `bus_data_o` out 32: write data.
- `bus_ce_o` out 1: bus request.
- `bus_we_o` out 1: write enable; equals `bus_ce_o` in this block.
- `bus_ack_i` in 1: RAM controller completion.
- `busy` out 1: load in progress.
- `done` out 1: load finished; held until the next accepted `start`.
- `words_o` out LEN_W: number of words written so far.
- `csum_o` out 32: running checksum (see Configuration).

## Operation
- The state machine has four states: IDLE, COLLECT, WRITE, FINISH.
- **IDLE:**
  - `start` and `len_i`≠0: latch the length, clear `words_o`, the byte index, `done` and `csum_o`; go to COLLECT.
  - `start` and `len_i`=0: clear `done` as above; go to FINISH.
- **COLLECT:**
  - `byte_ready`=1.
  - Each cycle with `byte_valid`&&`byte_ready` stores the byte into lane `idx` (byte 0 goes to bits [7:0]) and increments the 2-bit `idx`.
  - The fourth byte (`idx`=3) goes to WRITE.
- **WRITE:**
  - Drives `bus_ce_o`=`bus_we_o`=1, `bus_addr_o`=BASE_ADDR+`words_o`, and the assembled `bus_data_o`.
  - These are held stable until `bus_ack_i` is sampled high.
  - On ack: `words_o` increments and `csum_o` is updated.
  - If the new count equals the latched length, go to FINISH; otherwise go to COLLECT.
- **FINISH:** `done`=1, `busy`=0; go to IDLE in the same cycle. `done` stays high while in IDLE.
- `busy`=1 in COLLECT and WRITE.
- `start` is ignored outside IDLE.
- `byte_ready`=0 outside COLLECT; bytes offered then are not consumed.
- The address adds modulo 2^32.
- `words_o` never exceeds the latched length.
- Reset at any time:
  - the state returns to IDLE;
  - any partial word is discarded;
  - all outputs go to 0, including the bus outputs, so an in-flight write is abandoned.

## Timing
- Reset values: `byte_ready`, `bus_ce_o`, `bus_we_o`, `busy`, `done` = 0; `bus_addr_o`, `bus_data_o`, `csum_o`, `words_o` = 0.
- All outputs are registered, so there is no combinational path from any input to any output.
- `start` at edge N: `busy` is high after N; the first byte can be accepted at edge N+1.
- Fourth byte accepted at edge M: `bus_ce_o` is high after M.
- `bus_ack_i` high at edge K:
  - `bus_ce_o` drops after K;
  - `byte_ready` rises after K if more words remain.
- Minimum is 5 cycles per word with a 1-cycle ack.
- An ack that arrives while `bus_ce_o`=0 is ignored.
- Last ack at edge K: after K the state is FINISH (`done`=1); after K+1 the state is IDLE.

## Configuration
- `LOADER_CSUM_EN` defined:
  - on every acked write, `csum_o` <= `csum_o` + `bus_data_o` (32-bit wrap);
  - `csum_o` is cleared by an accepted `start`.
- `LOADER_CSUM_EN` undefined:
  - `csum_o` is constant 0;
  - no adder is synthesized;
  - all other behaviour is identical.

## Test plan
- **Single word:** `len_i`=1; bytes 78,56,34,12; ack after 1 cycle -> one write: addr 0x00000000, data 0x12345678; `words_o`=1; `done`=1; `csum_o`=0x12345678 (only with the checksum macro).
- **Three words with throttling:** BASE_ADDR=0x100; `byte_valid` gaps of 0–3 cycles; ack delayed 4 cycles -> writes to 0x100, 0x101, 0x102; address and data stable through every wait cycle; `byte_ready`=0 during WRITE.
- **Zero length:** `len_i`=0 -> no bus activity; `done`=1 two cycles after `start`.
- **Reset mid-write:** drop `rst` while `bus_ce_o`=1 after two of four words -> all outputs 0 immediately (asynchronously); a new `start` with `len_i`=2 reloads from BASE_ADDR.
- **Start while busy:** pulse `start` with `len_i`=9 in the middle of a `len_i`=2 load -> exactly 2 words are written; `words_o`=2.
- **Checksum wrap:** two words 0xFFFFFFFF and 0x00000002 -> `csum_o`=0x00000001 when `LOADER_CSUM_EN` is defined; 0 otherwise.
